// File: rtl/fx_pkg.sv
// Shared fixed-point helpers: rounding-mode codes and two's-complement saturation bounds.
package fx_pkg;

  localparam int RND_FLOOR   = 0;
  localparam int RND_HALF_UP = 1;

  function automatic logic signed [31:0] sat_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] sat_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fx_sat.sv
// Combinational two's-complement saturate from IN_W down to OUT_W bits, with overflow flag.
module fx_sat
  import fx_pkg::*;
#(
  parameter int IN_W  = 15,
  parameter int OUT_W = 12
) (
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] q,
  output logic             ovf
);

  localparam logic signed [31:0] HI = sat_max(OUT_W);
  localparam logic signed [31:0] LO = sat_min(OUT_W);
  localparam logic [OUT_W-1:0] HI_Q = HI[OUT_W-1:0];
  localparam logic [OUT_W-1:0] LO_Q = LO[OUT_W-1:0];

  // Dropped MSBs plus the kept sign bit must all agree for the value to fit.
  logic [IN_W-OUT_W:0] top;
  assign top = d[IN_W-1:OUT_W-1];

  assign ovf = !((&top) || !(|top));
  assign q   = ovf ? (d[IN_W-1] ? LO_Q : HI_Q) : d[OUT_W-1:0];

endmodule

// File: rtl/fx_narrow.sv
// Two-stage elastic fixed-point narrowing: S1 round/truncate, S2 saturate (fx_sat).
// Define FX_NARROW_SAT_CNT_EN to add the o_sat_cnt saturated-beat counter.
module fx_narrow
  import fx_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = 10,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 8,
  parameter int RND      = RND_HALF_UP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_ovf,
  output logic             o_ovf_sticky,
  input  logic             i_clr
`ifdef FX_NARROW_SAT_CNT_EN
  ,
  output logic [15:0]      o_sat_cnt
`endif
);

  localparam int D    = IN_FRAC - OUT_FRAC;
  localparam int HD   = (D > 0) ? D - 1 : 0;
  localparam int S1_W = IN_W + 1 - D;
  localparam int S2_W = (S1_W > OUT_W) ? S1_W : OUT_W + 1;
  localparam logic signed [IN_W:0] HALF =
    (RND == RND_HALF_UP && D > 0) ? ((IN_W + 1)'(1) << HD) : '0;

  // One extra bit of headroom so the rounding carry of the max positive input survives.
  logic signed [IN_W:0]   sum;
  logic signed [S1_W-1:0] s1_data;
  logic                   s1_valid;
  logic signed [S2_W-1:0] s2_in;
  logic [OUT_W-1:0]       sat_q;
  logic                   sat_ovf;
  logic                   s1_adv;
  logic                   s1_load;

  assign sum     = $signed({i_data[IN_W-1], i_data}) + HALF;
  assign s2_in   = S2_W'(s1_data);
  assign s1_adv  = s1_valid && (!o_valid || o_ready);
  assign i_ready = !rst && (!s1_valid || !o_valid || o_ready);
  assign s1_load = i_valid && i_ready;

  fx_sat #(
    .IN_W (S2_W),
    .OUT_W(OUT_W)
  ) u_sat (
    .d  (s2_in),
    .q  (sat_q),
    .ovf(sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_ovf        <= 1'b0;
      o_ovf_sticky <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= S1_W'(sum >>> D);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        o_valid <= 1'b1;
        o_data  <= sat_q;
        o_ovf   <= sat_ovf;
      end else if (o_ready) begin
        o_valid <= 1'b0;
        o_ovf   <= 1'b0;
      end

      // A saturation entering S2 wins over a coincident clear.
      if (s1_adv && sat_ovf) begin
        o_ovf_sticky <= 1'b1;
      end else if (i_clr) begin
        o_ovf_sticky <= 1'b0;
      end
    end
  end

`ifdef FX_NARROW_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      o_sat_cnt <= '0;
    end else if (o_valid && o_ready && o_ovf && o_sat_cnt != 16'hFFFF) begin
      o_sat_cnt <= o_sat_cnt + 16'd1;
    end
  end
`endif

endmodule
